// File: rtl/rot_pkg.sv
// Shared types and helpers for the pipelined shift/rotate block.
package rot_pkg;

  typedef enum logic [1:0] {
    ROR = 2'd0,
    ROL = 2'd1,
    SRL = 2'd2,
    SRA = 2'd3
  } rot_mode_t;

  // Shift distance handled by pipeline stage s.
  function automatic int unsigned stage_shift(input int unsigned n, input int unsigned s);
    return n >> (s + 1);
  endfunction

endpackage

// File: rtl/rot_pipe_stage.sv
// One registered mux stage of rot_pipe; shifts by N>>(STAGE+1) when k[STAGE] is set.
// Tag sideband registers exist only when ROT_PIPE_TAG_EN is defined.
module rot_pipe_stage
  import rot_pkg::*;
#(
  parameter int unsigned N     = 128,
  parameter int unsigned LOG2N = 7,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned STAGE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_valid,
  input  logic [0:N-1]     i_data,
  input  logic [0:LOG2N-1] i_k,
  input  rot_mode_t        i_mode,
  input  logic             i_sign,
`ifdef ROT_PIPE_TAG_EN
  input  logic [TAG_W-1:0] i_tag,
  output logic [TAG_W-1:0] o_tag,
`endif
  output logic             o_valid,
  output logic [0:N-1]     o_data,
  output logic [0:LOG2N-1] o_k,
  output rot_mode_t        o_mode,
  output logic             o_sign
);

  localparam int unsigned Sh = stage_shift(N, STAGE);

  logic             r_valid;
  logic [0:N-1]     r_data;
  logic [0:LOG2N-1] r_k;
  rot_mode_t        r_mode;
  logic             r_sign;
  logic [0:N-1]     w_shifted;
  logic [LOG2N-1:0] w_idx_dn;
  logic [LOG2N-1:0] w_idx_up;

  // Index arithmetic wraps at LOG2N bits, which is exactly mod N.
  always_comb begin
    w_shifted = i_data;
    w_idx_dn  = '0;
    w_idx_up  = '0;
    if (i_k[STAGE]) begin
      for (int unsigned j = 0; j < N; j++) begin
        w_idx_dn = LOG2N'(j - Sh);
        w_idx_up = LOG2N'(j + Sh);
        unique case (i_mode)
          ROR: w_shifted[j] = i_data[w_idx_dn];
          ROL: w_shifted[j] = i_data[w_idx_up];
          SRL: w_shifted[j] = (j < Sh) ? 1'b0 : i_data[w_idx_dn];
          SRA: w_shifted[j] = (j < Sh) ? i_sign : i_data[w_idx_dn];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_k     <= '0;
      r_mode  <= ROR;
      r_sign  <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_data  <= w_shifted;
      r_k     <= i_k;
      r_mode  <= i_mode;
      r_sign  <= i_sign;
    end
  end

`ifdef ROT_PIPE_TAG_EN
  logic [TAG_W-1:0] r_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag <= '0;
    end else if (i_load) begin
      r_tag <= i_tag;
    end
  end

  assign o_tag = r_tag;
`else
  localparam int unsigned unused_tag_w = TAG_W;
`endif

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_k     = r_k;
  assign o_mode  = r_mode;
  assign o_sign  = r_sign;

endmodule

// File: rtl/rot_pipe.sv
// Pipelined ROR/ROL/SRL/SRA on an N-bit word, one stage per shift-amount bit.
// Define ROT_PIPE_TAG_EN to carry an in_tag/out_tag sideband alongside each word.
module rot_pipe
  import rot_pkg::*;
#(
  parameter int unsigned N      = 128,
  parameter int unsigned log2_N = 7,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:N-1]      in_bits,
  input  logic [0:log2_N-1] in_k,
  input  logic [1:0]        in_mode,
`ifdef ROT_PIPE_TAG_EN
  input  logic [TAG_W-1:0]  in_tag,
  output logic [TAG_W-1:0]  out_tag,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:N-1]      out_bits
);

  // Element 0 is the input port; element s+1 is the register of stage s.
  logic              w_valid [log2_N+1];
  logic [0:N-1]      w_data  [log2_N+1];
  logic [0:log2_N-1] w_k     [log2_N+1];
  rot_mode_t         w_mode  [log2_N+1];
  logic              w_sign  [log2_N+1];
  logic              w_ready [log2_N];
  logic              w_unused_tail;

  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_bits;
  assign w_k[0]     = in_k;
  assign w_mode[0]  = rot_mode_t'(in_mode);
  assign w_sign[0]  = in_bits[0];

  // r[s] = !v[s] | r[s+1] unrolled, so each stage is ready if any stage from it onward is empty.
  always_comb begin
    for (int unsigned s = 0; s < log2_N; s++) begin
      w_ready[s] = out_ready;
      for (int unsigned t = s; t < log2_N; t++) begin
        if (!w_valid[t+1]) w_ready[s] = 1'b1;
      end
    end
  end

`ifdef ROT_PIPE_TAG_EN
  logic [TAG_W-1:0] w_tag [log2_N+1];
  assign w_tag[0] = in_tag;
  assign out_tag  = w_tag[log2_N];
`endif

  for (genvar s = 0; s < log2_N; s++) begin : g_stage
    rot_pipe_stage #(
      .N     (N),
      .LOG2N (log2_N),
      .TAG_W (TAG_W),
      .STAGE (s)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_ready[s]),
      .i_valid (w_valid[s]),
      .i_data  (w_data[s]),
      .i_k     (w_k[s]),
      .i_mode  (w_mode[s]),
      .i_sign  (w_sign[s]),
`ifdef ROT_PIPE_TAG_EN
      .i_tag   (w_tag[s]),
      .o_tag   (w_tag[s+1]),
`endif
      .o_valid (w_valid[s+1]),
      .o_data  (w_data[s+1]),
      .o_k     (w_k[s+1]),
      .o_mode  (w_mode[s+1]),
      .o_sign  (w_sign[s+1])
    );
  end

  assign in_ready  = w_ready[0] | rst;
  assign out_valid = w_valid[log2_N];
  assign out_bits  = w_data[log2_N];

  assign w_unused_tail = ^{w_k[log2_N], w_mode[log2_N], w_sign[log2_N]};

endmodule

// File: tb/tb_rot_pipe.sv
// Self-checking bench for rot_pipe at N=8: directed modes, streaming, backpressure, reset.
module tb_rot_pipe;

  localparam int unsigned N  = 8;
  localparam int unsigned L  = 3;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [0:N-1]  in_bits;
  logic [0:L-1]  in_k;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [0:N-1]  out_bits;
  logic [TW-1:0] in_tag;
`ifdef ROT_PIPE_TAG_EN
  logic [TW-1:0] out_tag;
`endif

  always #5 clk = ~clk;

  rot_pipe #(
    .N      (N),
    .log2_N (L),
    .TAG_W  (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bits   (in_bits),
    .in_k      (in_k),
    .in_mode   (in_mode),
`ifdef ROT_PIPE_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits)
  );

  typedef struct {
    logic [0:N-1]  data;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           n_fail   = 0;
  int           pops     = 0;
  int           lat;
  int           acc;
  int           p0;
  int           n;
  logic         use_dir  = 1'b0;
  logic [0:N-1] dir_exp;
  logic         have_ref;
  logic         took;
  logic [0:N-1] ref_bits;

  function automatic logic [0:N-1] model(input logic [0:N-1] d, input logic [0:L-1] k,
                                         input logic [1:0] m);
    logic [0:N-1] r;
    int kk;
    kk = int'(k);
    r  = '0;
    for (int j = 0; j < N; j++) begin
      case (m)
        2'd0: r[j] = d[(j - kk + N) % N];
        2'd1: r[j] = d[(j + kk) % N];
        2'd2: if (j < kk) r[j] = 1'b0; else r[j] = d[j - kk];
        default: if (j < kk) r[j] = d[0]; else r[j] = d[j - kk];
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Scoreboard: push on accept, pop/compare on output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_has_expectation", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("out_bits", 32'(out_bits), 32'(e.data));
`ifdef ROT_PIPE_TAG_EN
          chk("out_tag", 32'(out_tag), 32'(e.tag));
`endif
        end
        pops++;
      end
      if (in_valid && in_ready) begin
        e.data = use_dir ? dir_exp : model(in_bits, in_k, in_mode);
        e.tag  = in_tag;
        sb.push_back(e);
      end
    end
  end

  task automatic directed(input string nm, input logic [0:N-1] d, input logic [0:L-1] k,
                          input logic [1:0] m, input logic [0:N-1] want);
    in_bits  = d;
    in_k     = k;
    in_mode  = m;
    dir_exp  = want;
    use_dir  = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    use_dir  = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd3);
    @(posedge clk); #1;
  endtask

  task automatic rand_word();
    in_bits = N'($urandom);
    in_k    = L'($urandom_range(0, N - 1));
    in_mode = 2'($urandom_range(0, 3));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bits = '0; in_k = '0; in_mode = '0;
    out_ready = 1'b1; in_tag = '0;
    @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bits", 32'(out_bits), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    directed("ror", 8'b10010110, 3'd3, 2'd0, 8'b11010010);
    directed("rol", 8'b10010110, 3'd3, 2'd1, 8'b10110100);
    directed("srl", 8'b10010110, 3'd3, 2'd2, 8'b00010010);
    directed("sra", 8'b10010110, 3'd3, 2'd3, 8'b11110010);
    directed("srl_k7", 8'b10010110, 3'd7, 2'd2, 8'b00000001);
    directed("k0_ror", 8'b10100101, 3'd0, 2'd0, 8'b10100101);
    directed("k0_rol", 8'b00111100, 3'd0, 2'd1, 8'b00111100);
    directed("k0_srl", 8'b11000011, 3'd0, 2'd2, 8'b11000011);
    directed("k0_sra", 8'b10011001, 3'd0, 2'd3, 8'b10011001);

    // Full-rate stream: one accept and (after fill) one result every cycle.
    for (int i = 0; i < 16; i++) begin
      rand_word();
      in_valid = 1'b1;
      @(negedge clk);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      if (i >= 3) chk("stream_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stream_tail_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: consumer stalled while producer keeps offering.
    out_ready = 1'b0;
    rand_word();
    in_valid = 1'b1;
    acc = 0;
    have_ref = 1'b0;
    p0 = pops;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      took = in_ready;
      if (took) acc++;
      if (out_valid) begin
        if (!have_ref) begin
          ref_bits = out_bits;
          have_ref = 1'b1;
        end else begin
          chk("stall_out_stable", 32'(out_bits), 32'(ref_bits));
        end
      end
      @(posedge clk); #1;
      if (took) rand_word();
    end
    chk("bp_accepts", 32'(acc), 32'd3);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_out_valid_held", 32'(out_valid), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_drained", 32'(sb.size()), 32'd0);
    chk("bp_pops", 32'(pops - p0), 32'd3);

    // Reset with three words in flight; a word offered during reset is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_word();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    rand_word();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_during", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_stale", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end

`ifdef ROT_PIPE_TAG_EN
    // Tags 0..15 under a random stall pattern must emerge in order with their words.
    for (int t = 0; t < 16; t++) begin
      rand_word();
      in_tag   = TW'(t);
      in_valid = 1'b1;
      took = 1'b0;
      n = 0;
      while (!took && n < 50) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        took = in_ready;
        @(posedge clk); #1;
        n++;
      end
      chk("tag_accepted", 32'(took), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("tag_drained", 32'(sb.size()), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
